// File: rtl/fsk_tx_pkg.sv
// fsk_tx_pkg: shared constants, state encoding and output arithmetic for the
// FSK transmitter.
//   NP          samples per bit period (the sine table below is built for 100)
//   SH0         DC offset code of the offset-binary output
//   DIV_FD_DEF  default clk cycles per ce_Fd pulse
//   NGAP_DEF    default idle gap length in ce_Fd ticks (must be >= NP)
//   AMP         sine amplitude in output codes
package fsk_tx_pkg;

  localparam int unsigned NP         = 100;
  localparam int unsigned SH0        = 2048;
  localparam int unsigned DIV_FD_DEF = 417;
  localparam int unsigned NGAP_DEF   = 100;
  localparam int unsigned AMP        = 1000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } state_e;

  // Offset the signed sine value by SH0 in 13-bit signed arithmetic. The
  // 13-bit result can never exceed 4095, so only the low side needs clamping.
  function automatic logic [11:0] sat_sum(input logic signed [10:0] s);
    logic signed [12:0] sum;
    sum = $signed(13'(SH0)) + 13'(s);
    if (sum[12]) begin
      return '0;
    end
    return sum[11:0];
  endfunction

endpackage

// File: rtl/fsk_sin_rom.sv
// fsk_sin_rom: combinational sine table, round(AMP*sin(2*pi*ph/NP)).
//   ph   in   7  table index 0..NP-1 (out-of-range indices read 0)
//   val  out 11  signed sine value
module fsk_sin_rom
  import fsk_tx_pkg::*;
(
  input  logic        [6:0]  ph,
  output logic signed [10:0] val
);

  localparam logic [6:0] Q1 = 7'(NP / 4);
  localparam logic [6:0] Q2 = 7'(NP / 2);
  localparam logic [6:0] Q3 = 7'((3 * NP) / 4);
  localparam logic [6:0] Q4 = 7'(NP);

  // First quadrant, i = 0..NP/4, for NP = 100 and AMP = 1000.
  function automatic logic [9:0] quarter(input logic [6:0] i);
    case (i)
      7'd0:  return 10'd0;
      7'd1:  return 10'd63;
      7'd2:  return 10'd125;
      7'd3:  return 10'd187;
      7'd4:  return 10'd249;
      7'd5:  return 10'd309;
      7'd6:  return 10'd368;
      7'd7:  return 10'd426;
      7'd8:  return 10'd482;
      7'd9:  return 10'd536;
      7'd10: return 10'd588;
      7'd11: return 10'd637;
      7'd12: return 10'd685;
      7'd13: return 10'd729;
      7'd14: return 10'd771;
      7'd15: return 10'd809;
      7'd16: return 10'd844;
      7'd17: return 10'd876;
      7'd18: return 10'd905;
      7'd19: return 10'd930;
      7'd20: return 10'd951;
      7'd21: return 10'd969;
      7'd22: return 10'd982;
      7'd23: return 10'd992;
      7'd24: return 10'd998;
      7'd25: return 10'd1000;
      default: return 10'd0;
    endcase
  endfunction

  logic [6:0] idx;
  logic       neg;
  logic [9:0] mag;

  // Full NP-entry table folded onto one quadrant via sine symmetry.
  always_comb begin
    idx = '0;
    neg = 1'b0;
    if (ph <= Q1) begin
      idx = ph;
    end else if (ph <= Q2) begin
      idx = Q2 - ph;
    end else if (ph <= Q3) begin
      idx = ph - Q2;
      neg = 1'b1;
    end else if (ph < Q4) begin
      idx = Q4 - ph;
      neg = 1'b1;
    end
    mag = quarter(idx);
    val = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end

endmodule

// File: rtl/fsk_tx.sv
// fsk_tx: FSK modulator. Sends one byte per accepted request as a 10-bit
// frame (start, 8 data LSB-first, stop) followed by an idle gap. A '1' bit is
// one sine cycle per bit period, a '0' bit two cycles.
//   clk     in   1  system clock
//   rst     in   1  asynchronous active-high reset
//   st      in   1  start request pulse, honoured only while busy=0
//   dat     in   8  byte to send, captured on accepted st
//   FSK_SH  out 12  offset-binary sample, registered
//   ce_Fd   out  1  sample strobe, one clk every DIV_FD clk
//   busy    out  1  frame in progress (accept through end of gap)
//   tx_bit  out  1  bit on air (1 when idle / in gap)
//   cb_bit  out  4  index of bit on air, 0 = start .. 9 = stop
//   done    out  1  pulse on the ce_Fd that ends the gap
module fsk_tx #(
  parameter int unsigned DIV_FD = fsk_tx_pkg::DIV_FD_DEF,
  parameter int unsigned NGAP   = fsk_tx_pkg::NGAP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st,
  input  logic [7:0]  dat,
  output logic [11:0] FSK_SH,
  output logic        ce_Fd,
  output logic        busy,
  output logic        tx_bit,
  output logic [3:0]  cb_bit,
  output logic        done
);

  import fsk_tx_pkg::*;

  localparam int unsigned DW = (DIV_FD > 1) ? $clog2(DIV_FD) : 1;
  localparam int unsigned GW = $clog2(NGAP + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_FD - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(NGAP - 1);
  localparam logic [6:0]    K_LAST   = 7'(NP - 1);

  state_e             state_q, state_d;
  logic [DW-1:0]      div_q, div_d;
  logic [6:0]         k_q, k_d;
  logic [6:0]         ph_q, ph_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [7:0]         sh_q, sh_d;
  logic               tx_q, tx_d;
  logic [3:0]         cb_q, cb_d;
  logic               busy_q, busy_d;
  logic [11:0]        out_q, out_d;

  logic               ce;
  logic signed [10:0] rom_val;
  logic [6:0]         ph_step;
  logic [6:0]         ph_wrap;

  fsk_sin_rom u_rom (
    .ph  (ph_q),
    .val (rom_val)
  );

  assign ce      = (div_q == DIV_LAST);
  assign ph_step = ph_q + (tx_q ? 7'd1 : 7'd2);
  assign ph_wrap = (ph_step >= 7'(NP)) ? ph_step - 7'(NP) : ph_step;

  always_comb begin
    state_d = state_q;
    div_d   = ce ? '0 : div_q + DW'(1);
    k_d     = k_q;
    ph_d    = ph_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    cb_d    = cb_q;
    busy_d  = busy_q;
    out_d   = out_q;

    case (state_q)
      IDLE: begin
        if (st) begin
          sh_d    = dat;
          busy_d  = 1'b1;
          cb_d    = '0;
          tx_d    = 1'b0;
          k_d     = '0;
          ph_d    = '0;
          state_d = START;
        end
      end

      START, DATA, STOP: begin
        if (ce) begin
          out_d = sat_sum(rom_val);
          ph_d  = ph_wrap;
          k_d   = k_q + 7'd1;
          if (k_q == K_LAST) begin
            k_d  = '0;
            ph_d = '0;
            cb_d = cb_q + 4'd1;
            if (state_q == START) begin
              tx_d    = sh_q[0];
              sh_d    = sh_q >> 1;
              state_d = DATA;
            end else if (state_q == DATA) begin
              if (cb_q == 4'd8) begin
                tx_d    = 1'b1;
                state_d = STOP;
              end else begin
                tx_d = sh_q[0];
                sh_d = sh_q >> 1;
              end
            end else begin
              tx_d    = 1'b1;
              cb_d    = '0;
              gap_d   = '0;
              state_d = GAP;
            end
          end
        end
      end

      GAP: begin
        if (ce) begin
          out_d = 12'(SH0);
          if (gap_q == GAP_LAST) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      k_q     <= '0;
      ph_q    <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      cb_q    <= '0;
      busy_q  <= 1'b0;
      out_q   <= 12'(SH0);
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      k_q     <= k_d;
      ph_q    <= ph_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      cb_q    <= cb_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
    end
  end

  assign FSK_SH = out_q;
  assign ce_Fd  = ce;
  assign busy   = busy_q;
  assign tx_bit = tx_q;
  assign cb_bit = cb_q;
  assign done   = ce && (state_q == GAP) && (gap_q == GAP_LAST);

endmodule

// File: tb/tb_fsk_tx.sv
module tb_fsk_tx;

  localparam int DIVT  = 4;
  localparam int NPT   = 100;
  localparam int NGAPT = 100;
  localparam int NBITS = 10 * NPT;
  localparam int FRAME = NBITS + NGAPT;
  localparam real PI   = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst;
  logic        st;
  logic [7:0]  dat;
  logic [11:0] FSK_SH;
  logic        ce_Fd;
  logic        busy;
  logic        tx_bit;
  logic [3:0]  cb_bit;
  logic        done;

  fsk_tx #(.DIV_FD(DIVT), .NGAP(NGAPT)) dut (
    .clk    (clk),
    .rst    (rst),
    .st     (st),
    .dat    (dat),
    .FSK_SH (FSK_SH),
    .ce_Fd  (ce_Fd),
    .busy   (busy),
    .tx_bit (tx_bit),
    .cb_bit (cb_bit),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] cap_sh   [FRAME];
  logic        cap_tx   [FRAME];
  logic [3:0]  cap_cb   [FRAME];
  logic        cap_done [FRAME];
  int          first_lat;
  bit          cap_ok;

  typedef struct {
    logic [7:0]  dat;
    int          tick;
    logic [11:0] sh;
    logic        tx;
    logic [3:0]  cb;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: frame as bit list + ideal sine ----------
  function automatic int bit_of(input logic [7:0] d, input int b);
    if (b == 0) return 0;
    if (b == 9) return 1;
    return int'(d[b-1]);
  endfunction

  function automatic int exp_sample(input logic [7:0] d, input int t);
    int  b, k, ph, cyc;
    real x;
    if (t >= NBITS) return 2048;
    b   = t / NPT;
    k   = t % NPT;
    cyc = (bit_of(d, b) != 0) ? 1 : 2;
    ph  = (cyc * k) % NPT;
    x   = 1000.0 * $sin(2.0 * PI * real'(ph) / real'(NPT));
    return 2048 + $rtoi((x >= 0.0) ? x + 0.5 : x - 0.5);
  endfunction

  function automatic int exp_tx(input logic [7:0] d, input int t);
    if (t >= NBITS) return 1;
    return bit_of(d, t / NPT);
  endfunction

  // ---------------- stimulus helpers ----------------------------------------
  task automatic wait_ce(output bit ok, output int lat);
    int n;
    n   = 0;
    ok  = 1'b0;
    lat = 0;
    while (!ok && n < 2 * DIVT) begin
      @(negedge clk);
      n++;
      if (ce_Fd) ok = 1'b1;
    end
    lat = n;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL tick_timeout: got no ce_Fd in %0d clk, expected one", 2 * DIVT);
    end
  endtask

  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    st  = 1'b1;
    dat = d;
    @(posedge clk);
    #1;
    st = 1'b0;
    check("busy_on_accept", busy, 1);
    check("tx_on_accept", tx_bit, 0);
    check("cb_on_accept", cb_bit, 0);
  endtask

  task automatic capture(input int from, input int to, input bit poke_mid,
                         input bit poke_done, input logic [7:0] d);
    bit ok;
    int lat;
    for (int t = from; t < to; t++) begin
      wait_ce(ok, lat);
      if (!ok) begin
        cap_ok = 1'b0;
        return;
      end
      if (t == 0) first_lat = lat;
      cap_tx[t]   = tx_bit;
      cap_cb[t]   = cb_bit;
      cap_done[t] = done;
      if (poke_done && done) begin
        st  = 1'b1;
        dat = ~d;
      end
      @(posedge clk);
      #1;
      st = 1'b0;
      cap_sh[t] = FSK_SH;
      // This posedge directly follows a ce edge, so it never is a tick.
      if (poke_mid && t == 499) begin
        st  = 1'b1;
        dat = ~d;
        @(posedge clk);
        #1;
        st = 1'b0;
        check("busy_st_mid", busy, 1);
      end
    end
  endtask

  task automatic verify_frame(input logic [7:0] d);
    int npulse, pos;
    bit bad;
    check("first_latency_ok", int'(first_lat >= 1 && first_lat <= DIVT), 1);
    npulse = 0;
    pos    = -1;
    for (int t = 0; t < FRAME; t++) begin
      bad = (int'(cap_sh[t]) != exp_sample(d, t)) || (int'(cap_tx[t]) != exp_tx(d, t));
      if (t < NBITS && int'(cap_cb[t]) != t / NPT) bad = 1'b1;
      n_vec++;
      if (bad) begin
        n_err++;
        $display("FAIL sample dat=%02h tick=%0d: got sh=%0d tx=%0d cb=%0d, expected sh=%0d tx=%0d cb=%0d",
                 d, t, cap_sh[t], cap_tx[t], cap_cb[t], exp_sample(d, t), exp_tx(d, t),
                 (t < NBITS) ? t / NPT : -1);
      end
      if (cap_done[t]) begin
        npulse++;
        pos = t;
      end
    end
    check("done_pulses", npulse, 1);
    check("done_tick", pos, FRAME - 1);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit poke_mid, input bit poke_done);
    cap_ok = 1'b1;
    start_frame(d);
    capture(0, FRAME, poke_mid, poke_done, d);
    if (cap_ok) begin
      check("busy_after_done", busy, 0);
      verify_frame(d);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got time limit, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cur, r;
    int diff;

    rst = 1'b1;
    st  = 1'b0;
    dat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sh", FSK_SH, 2048);
    check("rst_busy", busy, 0);
    check("rst_tx", tx_bit, 1);
    check("rst_cb", cb_bit, 0);
    check("rst_done", done, 0);
    check("rst_ce", ce_Fd, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed points: {dat, tick, FSK_SH, tx_bit, cb_bit}; tick = 100*bit + k.
    tbl.push_back('{8'hFF,  13, 12'd3046, 1'b0, 4'd0});
    tbl.push_back('{8'hFF, 125, 12'd3048, 1'b1, 4'd1});
    tbl.push_back('{8'hFF, 375, 12'd1048, 1'b1, 4'd3});
    tbl.push_back('{8'hFF, 925, 12'd3048, 1'b1, 4'd9});
    tbl.push_back('{8'h00,  25, 12'd2048, 1'b0, 4'd0});
    tbl.push_back('{8'h00, 212, 12'd3046, 1'b0, 4'd2});
    tbl.push_back('{8'h00, 425, 12'd2048, 1'b0, 4'd4});
    tbl.push_back('{8'h00, 925, 12'd3048, 1'b1, 4'd9});
    tbl.push_back('{8'hA5,  25, 12'd2048, 1'b0, 4'd0});
    tbl.push_back('{8'hA5, 125, 12'd3048, 1'b1, 4'd1});
    tbl.push_back('{8'hA5, 225, 12'd2048, 1'b0, 4'd2});
    tbl.push_back('{8'hA5, 325, 12'd3048, 1'b1, 4'd3});
    tbl.push_back('{8'hA5, 425, 12'd2048, 1'b0, 4'd4});
    tbl.push_back('{8'hA5, 525, 12'd2048, 1'b0, 4'd5});
    tbl.push_back('{8'hA5, 625, 12'd3048, 1'b1, 4'd6});
    tbl.push_back('{8'hA5, 725, 12'd2048, 1'b0, 4'd7});
    tbl.push_back('{8'hA5, 825, 12'd3048, 1'b1, 4'd8});
    tbl.push_back('{8'hA5, 925, 12'd3048, 1'b1, 4'd9});

    cur = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 0 || tbl[i].dat != cur) begin
        cur = tbl[i].dat;
        run_frame(cur, 1'b0, 1'b0);
      end
      check($sformatf("tbl%0d_sh", i), cap_sh[tbl[i].tick], tbl[i].sh);
      check($sformatf("tbl%0d_tx", i), cap_tx[tbl[i].tick], tbl[i].tx);
      check($sformatf("tbl%0d_cb", i), cap_cb[tbl[i].tick], tbl[i].cb);
    end

    // Last table frame was A5: a bit-boundary step may not exceed the
    // steepest in-tone step of the two-cycle tone (ROM[2]-ROM[0] = 125).
    for (int b = 1; b < 10; b++) begin
      diff = int'(cap_sh[b*NPT]) - int'(cap_sh[b*NPT-1]);
      if (diff < 0) diff = -diff;
      check($sformatf("boundary%0d_step_le_126", b), int'(diff <= 126), 1);
    end

    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom);
      run_frame(r, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a frame.
    r = 8'($urandom);
    cap_ok = 1'b1;
    start_frame(r);
    capture(0, 350, 1'b0, 1'b0, r);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_sh", FSK_SH, 2048);
    check("midrst_busy", busy, 0);
    check("midrst_tx", tx_bit, 1);
    check("midrst_cb", cb_bit, 0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(8'($urandom), 1'b0, 1'b0);

    // st at tick 500 and on the done clk are ignored; the next st is taken.
    r = 8'($urandom);
    run_frame(r, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("busy_after_done_st", busy, 0);
    run_frame(8'($urandom), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
